// File: rtl/opnd_collect_if.sv
// ---------------------------------------------------------------------------
// opnd_collect_if
// Bundles the register-read stage's bus signals:
//   - ID side     : in_valid/in_ready handshake, source indices, source-used
//                   flags and the opaque decoded payload
//   - writeback   : wb_valid strobe, destination index, data
//   - hazard unit : rs1/rs2 bypass (valid + value), ex_stall flag
//   - EX side     : out_valid/out_ready handshake, held indices, flags,
//                   operand values and payload
// Modports:
//   slave  : the register-read stage (opnd_collect)
//   master : the surrounding pipeline / environment driving the stage
// ---------------------------------------------------------------------------
interface opnd_collect_if #(
  parameter int XLEN      = 32,
  parameter int RIDX_W    = 5,
  parameter int PAYLOAD_W = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [RIDX_W-1:0]    in_rs1;
  logic [RIDX_W-1:0]    in_rs2;
  logic                 in_has_rs1;
  logic                 in_has_rs2;
  logic [PAYLOAD_W-1:0] in_payload;

  logic                 wb_valid;
  logic [RIDX_W-1:0]    wb_rd;
  logic [XLEN-1:0]      wb_data;

  logic                 byp_rs1_valid;
  logic [XLEN-1:0]      byp_rs1_value;
  logic                 byp_rs2_valid;
  logic [XLEN-1:0]      byp_rs2_value;
  logic                 ex_stall;

  logic                 out_valid;
  logic                 out_ready;
  logic [RIDX_W-1:0]    out_rs1;
  logic [RIDX_W-1:0]    out_rs2;
  logic                 out_has_rs1;
  logic                 out_has_rs2;
  logic [XLEN-1:0]      out_rs1_value;
  logic [XLEN-1:0]      out_rs2_value;
  logic [PAYLOAD_W-1:0] out_payload;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_has_rs1, in_has_rs2, in_payload,
    output in_ready,
    input  wb_valid, wb_rd, wb_data,
    input  byp_rs1_valid, byp_rs1_value, byp_rs2_valid, byp_rs2_value, ex_stall,
    input  out_ready,
    output out_valid, out_rs1, out_rs2, out_has_rs1, out_has_rs2,
    output out_rs1_value, out_rs2_value, out_payload
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_has_rs1, in_has_rs2, in_payload,
    input  in_ready,
    output wb_valid, wb_rd, wb_data,
    output byp_rs1_valid, byp_rs1_value, byp_rs2_valid, byp_rs2_value, ex_stall,
    output out_ready,
    input  out_valid, out_rs1, out_rs2, out_has_rs1, out_has_rs2,
    input  out_rs1_value, out_rs2_value, out_payload
  );
endinterface

// File: rtl/opnd_collect.sv
// ---------------------------------------------------------------------------
// opnd_collect
// Register-read stage. Owns the integer register file (x0 reads as zero),
// reads rs1/rs2 for instructions accepted from ID, holds them in the RD->EX
// pipeline register, keeps the held operands fresh from bypass/writeback
// while waiting, and releases to EX when the hazard unit reports no stall.
//
// Ports:
//   i_clk          clock, all state on rising edge
//   i_rst          synchronous reset, active-high
//   i_en           stage enable; 0 freezes the pipeline register
//                  (register-file writeback still commits)
//   i_flush        kill the held instruction (branch redirect)
//   io_bus         opnd_collect_if.slave (ID, writeback, hazard, EX sides)
//   o_stall_cycles stall-cycle counter, only when OPND_COLLECT_STALL_CNT_EN
//                  is defined
//
// Optional feature macro: OPND_COLLECT_STALL_CNT_EN
//   Adds o_stall_cycles, counting cycles with a held instruction, ex_stall
//   and en all high; saturating; cleared by reset and flush.
// ---------------------------------------------------------------------------
module opnd_collect #(
  parameter int XLEN      = 32,
  parameter int REG_CNT   = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_flush,
  opnd_collect_if.slave io_bus
`ifdef OPND_COLLECT_STALL_CNT_EN
  ,
  output logic [31:0]  o_stall_cycles
`endif
);

  localparam int RIDX_W = $clog2(REG_CNT);

  logic [XLEN-1:0]      r_regs [REG_CNT];

  logic                 r_valid;
  logic [RIDX_W-1:0]    r_rs1;
  logic [RIDX_W-1:0]    r_rs2;
  logic                 r_has_rs1;
  logic                 r_has_rs2;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [XLEN-1:0]      r_op1;
  logic [XLEN-1:0]      r_op2;

  logic                 w_fire;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_wb_wr;
  logic [XLEN-1:0]      w_rd1;
  logic [XLEN-1:0]      w_rd2;
  logic                 w_wb_hit1;
  logic                 w_wb_hit2;

  // Handshake. in_ready is forced low during reset so nothing is taken while
  // the pipeline register is being cleared.
  assign w_fire     = r_valid & io_bus.out_ready & ~io_bus.ex_stall & i_en & ~i_flush;
  assign w_in_ready = ~i_rst & i_en & ~i_flush & (~r_valid | w_fire);
  assign w_accept   = io_bus.in_valid & w_in_ready;
  assign w_wb_wr    = io_bus.wb_valid & (io_bus.wb_rd != '0);

  // Source reads with write-through so a same-cycle writeback is not missed.
  always_comb begin
    w_rd1 = '0;
    if (io_bus.in_has_rs1 && (io_bus.in_rs1 != '0)) begin
      if (io_bus.wb_valid && (io_bus.wb_rd == io_bus.in_rs1)) begin
        w_rd1 = io_bus.wb_data;
      end else begin
        w_rd1 = r_regs[io_bus.in_rs1];
      end
    end
  end

  always_comb begin
    w_rd2 = '0;
    if (io_bus.in_has_rs2 && (io_bus.in_rs2 != '0)) begin
      if (io_bus.wb_valid && (io_bus.wb_rd == io_bus.in_rs2)) begin
        w_rd2 = io_bus.wb_data;
      end else begin
        w_rd2 = r_regs[io_bus.in_rs2];
      end
    end
  end

  // A writeback to a held, used, non-zero source refreshes the waiting operand.
  assign w_wb_hit1 = io_bus.wb_valid & (io_bus.wb_rd == r_rs1) & (r_rs1 != '0) & r_has_rs1;
  assign w_wb_hit2 = io_bus.wb_valid & (io_bus.wb_rd == r_rs2) & (r_rs2 != '0) & r_has_rs2;

  // Register file; writeback is independent of en. x0 is never written.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_wr) begin
      r_regs[io_bus.wb_rd] <= io_bus.wb_data;
    end
  end

  // RD->EX pipeline register. Flush outranks everything else; with en low the
  // register is frozen (no accept, no fire, no refresh).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_has_rs1 <= 1'b0;
      r_has_rs2 <= 1'b0;
      r_payload <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      if (w_accept) begin
        // Covers back-to-back fire+accept: the new instruction replaces the
        // departing one with no bubble.
        r_valid   <= 1'b1;
        r_rs1     <= io_bus.in_rs1;
        r_rs2     <= io_bus.in_rs2;
        r_has_rs1 <= io_bus.in_has_rs1;
        r_has_rs2 <= io_bus.in_has_rs2;
        r_payload <= io_bus.in_payload;
        r_op1     <= w_rd1;
        r_op2     <= w_rd2;
      end else if (w_fire) begin
        r_valid <= 1'b0;
      end else if (r_valid) begin
        // Waiting: bypass has priority over writeback.
        if (io_bus.byp_rs1_valid) begin
          r_op1 <= io_bus.byp_rs1_value;
        end else if (w_wb_hit1) begin
          r_op1 <= io_bus.wb_data;
        end
        if (io_bus.byp_rs2_valid) begin
          r_op2 <= io_bus.byp_rs2_value;
        end else if (w_wb_hit2) begin
          r_op2 <= io_bus.wb_data;
        end
      end
    end
  end

  assign io_bus.in_ready    = w_in_ready;
  assign io_bus.out_valid   = r_valid;
  assign io_bus.out_rs1     = r_rs1;
  assign io_bus.out_rs2     = r_rs2;
  assign io_bus.out_has_rs1 = r_has_rs1;
  assign io_bus.out_has_rs2 = r_has_rs2;
  assign io_bus.out_payload = r_payload;

  // A bypass presented in the fire cycle goes straight to EX.
  assign io_bus.out_rs1_value = io_bus.byp_rs1_valid ? io_bus.byp_rs1_value : r_op1;
  assign io_bus.out_rs2_value = io_bus.byp_rs2_valid ? io_bus.byp_rs2_value : r_op2;

`ifdef OPND_COLLECT_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_stall_cycles <= '0;
    end else if (r_valid && io_bus.ex_stall && i_en && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_opnd_collect.sv
module tb_opnd_collect;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic flush;

  always #5 clk = ~clk;

  opnd_collect_if #(.XLEN(32), .RIDX_W(5), .PAYLOAD_W(64)) bus ();

`ifdef OPND_COLLECT_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  opnd_collect #(.XLEN(32), .REG_CNT(32), .PAYLOAD_W(64)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (en),
    .i_flush (flush),
    .io_bus  (bus)
`ifdef OPND_COLLECT_STALL_CNT_EN
    ,
    .o_stall_cycles (stall_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: architectural register array plus the held instruction.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [4:0]  m_rs1, m_rs2;
  logic        m_h1, m_h2;
  logic [63:0] m_pay;
  logic [31:0] m_op1, m_op2;
  logic [31:0] m_cnt;
  logic        m_fire, m_rdy;
  int          b2b_fires;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] idx, input logic has);
    if (!has || idx == 5'd0) return 32'd0;
    if (bus.wb_valid && bus.wb_rd == idx) return bus.wb_data;
    return m_regs[idx];
  endfunction

  task automatic idle();
    rst = 1'b0; en = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_has_rs1 = 1'b0; bus.in_has_rs2 = 1'b0; bus.in_payload = '0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.byp_rs1_valid = 1'b0; bus.byp_rs1_value = '0;
    bus.byp_rs2_valid = 1'b0; bus.byp_rs2_value = '0;
    bus.ex_stall = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic offer(input logic [4:0] r1, input logic h1, input logic [4:0] r2,
                       input logic h2, input logic [63:0] p);
    bus.in_valid = 1'b1; bus.in_rs1 = r1; bus.in_has_rs1 = h1;
    bus.in_rs2 = r2; bus.in_has_rs2 = h2; bus.in_payload = p;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.wb_valid = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  // Compare every output against the model for the inputs now applied.
  task automatic sample();
    #1;
    m_fire = m_valid && bus.out_ready && !bus.ex_stall && en && !flush;
    m_rdy  = !rst && en && !flush && (!m_valid || m_fire);
    chk("in_ready",    bus.in_ready,    m_rdy);
    chk("out_valid",   bus.out_valid,   m_valid);
    chk("out_rs1",     bus.out_rs1,     m_rs1);
    chk("out_rs2",     bus.out_rs2,     m_rs2);
    chk("out_has_rs1", bus.out_has_rs1, m_h1);
    chk("out_has_rs2", bus.out_has_rs2, m_h2);
    chk("out_payload", bus.out_payload, m_pay);
    chk("out_rs1_value", bus.out_rs1_value, bus.byp_rs1_valid ? bus.byp_rs1_value : m_op1);
    chk("out_rs2_value", bus.out_rs2_value, bus.byp_rs2_valid ? bus.byp_rs2_value : m_op2);
`ifdef OPND_COLLECT_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_cnt);
`endif
  endtask

  // Advance the model by one clock with the current inputs, then move to the
  // next falling edge where new inputs are applied.
  task automatic advance();
    logic acc;
    logic [31:0] n1, n2;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_h1 = 0; m_h2 = 0;
      m_pay = 0; m_op1 = 0; m_op2 = 0; m_cnt = 0;
    end else begin
      acc = bus.in_valid && m_rdy;
      n1 = mread(bus.in_rs1, bus.in_has_rs1);
      n2 = mread(bus.in_rs2, bus.in_has_rs2);
      if (flush) m_cnt = 0;
      else if (m_valid && bus.ex_stall && en && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (flush) begin
        m_valid = 0;
      end else if (en) begin
        if (acc) begin
          m_valid = 1; m_rs1 = bus.in_rs1; m_rs2 = bus.in_rs2;
          m_h1 = bus.in_has_rs1; m_h2 = bus.in_has_rs2; m_pay = bus.in_payload;
          m_op1 = n1; m_op2 = n2;
        end else if (m_fire) begin
          m_valid = 0;
        end else if (m_valid) begin
          if (bus.byp_rs1_valid) m_op1 = bus.byp_rs1_value;
          else if (bus.wb_valid && bus.wb_rd == m_rs1 && m_rs1 != 0 && m_h1) m_op1 = bus.wb_data;
          if (bus.byp_rs2_valid) m_op2 = bus.byp_rs2_value;
          else if (bus.wb_valid && bus.wb_rd == m_rs2 && m_rs2 != 0 && m_h2) m_op2 = bus.wb_data;
        end
      end
      if (bus.wb_valid && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
    end
    @(negedge clk);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    advance();
    // Reset state, still in reset.
    rst = 1'b1;
    offer(5'd1, 1'b1, 5'd2, 1'b1, 64'h1);
    sample();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_payload", bus.out_payload, 64'h0);
    advance();

    // Writeback then read on the next cycle.
    idle(); wb(5'd5, 32'h1234); step();
    idle(); offer(5'd5, 1'b1, 5'd0, 1'b0, 64'hA1); step();
    idle(); bus.out_ready = 1'b0; sample();
    chk("wb_then_read", bus.out_rs1_value, 32'h1234);
    chk("rs2_unused_zero", bus.out_rs2_value, 32'h0);
    advance();
    idle(); step();

    // Same-cycle write-through.
    idle(); wb(5'd7, 32'hAA); offer(5'd7, 1'b1, 5'd0, 1'b0, 64'hA2); step();
    idle(); bus.out_ready = 1'b0; sample();
    chk("write_through", bus.out_rs1_value, 32'hAA);
    advance();
    idle(); step();

    // Writes to x0 are dropped.
    idle(); wb(5'd0, 32'hFFFF_FFFF); step();
    idle(); offer(5'd0, 1'b1, 5'd0, 1'b1, 64'hA3); step();
    idle(); bus.out_ready = 1'b0; sample();
    chk("x0_read", bus.out_rs1_value, 32'h0);
    advance();
    idle(); step();

    // Stall three cycles with a one-cycle rs2 bypass in the middle.
    idle(); offer(5'd2, 1'b1, 5'd3, 1'b1, 64'hDEAD_BEEF_0000_0004); step();
    idle(); bus.ex_stall = 1'b1; sample();
    chk("stall1_payload", bus.out_payload, 64'hDEAD_BEEF_0000_0004);
    advance();
    idle(); bus.ex_stall = 1'b1; bus.byp_rs2_valid = 1'b1; bus.byp_rs2_value = 32'h55; sample();
    chk("stall2_valid", bus.out_valid, 1'b1);
    advance();
    idle(); bus.ex_stall = 1'b1; sample();
    chk("stall3_rs2_latched", bus.out_rs2_value, 32'h55);
    chk("stall3_payload", bus.out_payload, 64'hDEAD_BEEF_0000_0004);
    advance();
    idle(); sample();
    chk("stall_fire_valid", bus.out_valid, 1'b1);
    chk("stall_fire_rs2", bus.out_rs2_value, 32'h55);
    advance();
    idle(); sample();
    chk("stall_after_fire", bus.out_valid, 1'b0);
    advance();

    // Back-to-back: four consecutive fires with no bubble.
    idle(); offer(5'd1, 1'b0, 5'd1, 1'b0, 64'hB0); step();
    b2b_fires = 0;
    for (int k = 1; k <= 4; k++) begin
      idle(); offer(5'd1, 1'b0, 5'd1, 1'b0, 64'hB0 + 64'(k)); sample();
      chk("b2b_payload", bus.out_payload, 64'hB0 + 64'(k - 1));
      chk("b2b_in_ready", bus.in_ready, 1'b1);
      if (bus.out_valid === 1'b1 && bus.out_ready && !bus.ex_stall) b2b_fires++;
      advance();
    end
    chk("b2b_fires", b2b_fires, 4);
    idle(); step();

    // Flush with a held instruction and a new offer.
    idle(); offer(5'd1, 1'b0, 5'd1, 1'b0, 64'hC0); bus.out_ready = 1'b0; step();
    idle(); flush = 1'b1; offer(5'd1, 1'b0, 5'd1, 1'b0, 64'hC1); sample();
    chk("flush_in_ready", bus.in_ready, 1'b0);
    advance();
    idle(); bus.out_ready = 1'b0; sample();
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_no_accept", bus.out_payload, 64'hC0);
    advance();

`ifdef OPND_COLLECT_STALL_CNT_EN
    idle(); offer(5'd1, 1'b0, 5'd1, 1'b0, 64'hD0); step();
    for (int k = 0; k < 5; k++) begin
      idle(); bus.ex_stall = 1'b1; step();
    end
    idle(); bus.ex_stall = 1'b1; sample();
    chk("cnt_five", stall_cycles, 32'd5);
    flush = 1'b1; advance();
    idle(); sample();
    chk("cnt_flushed", stall_cycles, 32'd0);
    advance();
`endif

    // Randomized traffic against the model, with occasional mid-run reset.
    for (int n = 0; n < 800; n++) begin
      idle();
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) < 6)
        offer(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
              {$urandom, $urandom});
      if ($urandom_range(0, 1) == 1)
        wb(($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
           $urandom);
      bus.byp_rs1_valid = ($urandom_range(0, 4) == 0); bus.byp_rs1_value = $urandom;
      bus.byp_rs2_valid = ($urandom_range(0, 4) == 0); bus.byp_rs2_value = $urandom;
      bus.ex_stall  = ($urandom_range(0, 9) < 3);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset clears the register file.
    idle(); wb(5'd9, 32'hCAFE); step();
    idle(); rst = 1'b1; step();
    idle(); offer(5'd9, 1'b1, 5'd9, 1'b1, 64'hE0); step();
    idle(); bus.out_ready = 1'b0; sample();
    chk("rst_clears_regfile", bus.out_rs1_value, 32'h0);
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
